// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared constants, register map, FSM states and SHA-256 helpers
package miner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL,
    ST_COMPARE,
    ST_DONE
  } miner_state_t;

  localparam logic [4:0] ADDR_CTRL   = 5'd0;
  localparam logic [4:0] ADDR_LEN    = 5'd1;
  localparam logic [4:0] ADDR_MSG_LO = 5'd3;
  localparam logic [4:0] ADDR_MSG_HI = 5'd15;
  localparam logic [4:0] ADDR_TGT_LO = 5'd16;
  localparam logic [4:0] ADDR_TGT_HI = 5'd23;
  localparam logic [4:0] ADDR_DIG_LO = 5'd24;
  localparam logic [4:0] ADDR_DIG_HI = 5'd31;

  localparam logic [8:0] MAX_LEN = 9'd416;

  localparam logic [31:0] SHA_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] SHA_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Single-block padding: keep the top len bits of the 416-bit buffer, append
  // the 1 marker directly after them, and place len big-endian in the last 64 bits.
  // The marker can land as low as bit 95 (len = 416), so it is built over 448 bits.
  function automatic logic [511:0] pad_block(input logic [415:0] msg, input logic [8:0] len);
    logic [415:0] keep_mask;
    logic [447:0] body;
    logic [447:0] marker;
    keep_mask = ~({416{1'b1}} >> len);
    marker    = {1'b1, 447'b0} >> len;
    body      = {msg & keep_mask, 32'b0} | marker;
    return {body, 55'b0, len};
  endfunction

endpackage

// File: rtl/sha256_core.sv
// rtl/sha256_core.sv - iterative single-block SHA-256 compression, one round per cycle
module sha256_core
  import miner_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [511:0] block,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest
);

  miner_state_t       state_q, state_d;
  logic [5:0]         round_q;
  logic [31:0]        v_q [8];
  logic [31:0]        v_d [8];
  logic [31:0]        w_q [16];
  logic [31:0]        w_new;
  logic [31:0]        t1, t2;
  logic [7:0][31:0]   digest_q;
  logic [15:0][31:0]  blk_w;
  logic               accept;

  assign blk_w  = block;
  assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign busy   = (state_q == ST_ROUND) || (state_q == ST_FINAL);
  assign done   = (state_q == ST_DONE);
  assign digest = digest_q;

  // Next-state: 64 rounds, one digest-add cycle, then hold in DONE until restarted
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_ROUND;
      ST_ROUND:         if (round_q == 6'd63) state_d = ST_FINAL;
      ST_FINAL:         state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // One compression round and the next rolling-schedule word; w_q[0] is W[t]
  always_comb begin
    t1 = v_q[7] + big_sigma1(v_q[4]) + ch(v_q[4], v_q[5], v_q[6]) + SHA_K[round_q] + w_q[0];
    t2 = big_sigma0(v_q[0]) + maj(v_q[0], v_q[1], v_q[2]);
    v_d[0] = t1 + t2;
    v_d[1] = v_q[0];
    v_d[2] = v_q[1];
    v_d[3] = v_q[2];
    v_d[4] = v_q[3] + t1;
    v_d[5] = v_q[4];
    v_d[6] = v_q[5];
    v_d[7] = v_q[6];
    w_new  = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
  end

  // Working variables, schedule window and digest; loading w_q snapshots the block
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      round_q  <= '0;
      digest_q <= '0;
      for (int i = 0; i < 8; i++)  v_q[i] <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else if (accept) begin
      round_q <= '0;
      for (int i = 0; i < 8; i++)  v_q[i] <= SHA_IV[i];
      for (int i = 0; i < 16; i++) w_q[i] <= blk_w[15-i];
    end else if (state_q == ST_ROUND) begin
      round_q <= round_q + 6'd1;
      for (int i = 0; i < 8; i++)  v_q[i] <= v_d[i];
      for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
      w_q[15] <= w_new;
    end else if (state_q == ST_FINAL) begin
      for (int i = 0; i < 8; i++) digest_q[7-i] <= SHA_IV[i] + v_q[i];
    end
  end

endmodule

// File: rtl/top_level_miner.sv
// rtl/top_level_miner.sv - register-mapped SHA-256 miner: register file, padding, target compare
module top_level_miner
  import miner_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic [4:0]  slaveAddr,
  input  logic [31:0] slaveWriteData,
  input  logic        slaveWrite,
  input  logic        slaveRead,
  input  logic        slaveChipSelect,
  output logic [31:0] slaveReadData
);

  miner_state_t      state_q, state_d;
  logic [5:0]        cnt_q;
  logic [12:0][31:0] msg_q;
  logic [8:0]        len_q;
  logic [7:0][31:0]  staged_q;
  logic [7:0][31:0]  target_q;
  logic [7:0][31:0]  dig_words;
  logic              valid_q;
  logic              busy, done;
  logic              wr_en, rd_en, commit, start_req, core_start;
  logic              in_msg, in_tgt, in_dig;
  logic [3:0]        msg_idx;
  logic [511:0]      block;
  logic              core_busy, core_done;
  logic [255:0]      core_digest;

  assign wr_en      = slaveWrite && slaveChipSelect;
  assign rd_en      = slaveRead && slaveChipSelect;
  assign commit     = wr_en && (slaveAddr == ADDR_CTRL) && slaveWriteData[0];
  assign start_req  = wr_en && (slaveAddr == ADDR_CTRL) && slaveWriteData[1];
  assign core_start = start_req && (state_q == ST_IDLE || state_q == ST_DONE);
  assign in_msg     = (slaveAddr >= ADDR_MSG_LO) && (slaveAddr <= ADDR_MSG_HI);
  assign in_tgt     = (slaveAddr[4:3] == ADDR_TGT_LO[4:3]);
  assign in_dig     = (slaveAddr[4:3] == ADDR_DIG_LO[4:3]);
  assign msg_idx    = slaveAddr[3:0] - ADDR_MSG_LO[3:0];
  assign busy       = (state_q == ST_ROUND) || (state_q == ST_FINAL) || (state_q == ST_COMPARE);
  assign done       = (state_q == ST_DONE);
  assign block      = pad_block(msg_q, len_q);
  assign dig_words  = core_digest;

  sha256_core u_core (
    .clk    (clk),
    .n_rst  (n_rst),
    .start  (core_start),
    .block  (block),
    .busy   (core_busy),
    .done   (core_done),
    .digest (core_digest)
  );

  // Next-state: mirrors the core's round count so COMPARE lands right after the digest add
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_req) state_d = ST_ROUND;
      ST_ROUND:         if (cnt_q == 6'd63) state_d = ST_FINAL;
      ST_FINAL:         state_d = ST_COMPARE;
      ST_COMPARE:       if (core_done && !core_busy) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // State register, round counter and the compare result
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (core_start) begin
        cnt_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        if (state_q == ST_ROUND) cnt_q <= cnt_q + 6'd1;
        if (state_q == ST_COMPARE && core_done) valid_q <= (core_digest < target_q);
      end
    end
  end

  // Bus-writable registers; writes while hashing only touch these staging copies
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      msg_q    <= '0;
      len_q    <= '0;
      staged_q <= '0;
      target_q <= '0;
    end else if (wr_en) begin
      if (slaveAddr == ADDR_LEN)
        len_q <= (slaveWriteData[8:0] > MAX_LEN) ? MAX_LEN : slaveWriteData[8:0];
      if (in_msg) msg_q[msg_idx] <= slaveWriteData;
      if (in_tgt) staged_q[slaveAddr[2:0]] <= slaveWriteData;
      if (commit) target_q <= staged_q;
    end
  end

  // Zero-wait-state read mux; idle bus reads as zero
  always_comb begin
    slaveReadData = '0;
    if (rd_en) begin
      if (slaveAddr == ADDR_CTRL)     slaveReadData = {29'b0, valid_q, done, busy};
      else if (slaveAddr == ADDR_LEN) slaveReadData = {23'b0, len_q};
      else if (in_msg)                slaveReadData = msg_q[msg_idx];
      else if (in_tgt)                slaveReadData = target_q[slaveAddr[2:0]];
      else if (in_dig)                slaveReadData = dig_words[slaveAddr[2:0]];
    end
  end

endmodule

// File: tb/tb_top_level_miner.sv
// tb/tb_top_level_miner.sv - directed scoreboard bench for top_level_miner
module tb_top_level_miner;

  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_A     = 256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb;
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        wr, rd, cs;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    string        tag;
    logic [255:0] digest;
    logic         valid;
  } exp_t;

  exp_t sb[$];

  top_level_miner dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .slaveAddr       (addr),
    .slaveWriteData  (wdata),
    .slaveWrite      (wr),
    .slaveRead       (rd),
    .slaveChipSelect (cs),
    .slaveReadData   (rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write_at(input int t, input logic [4:0] a, input logic [31:0] d, output int e);
    @(negedge clk);
    while (cyc < t - 1) @(negedge clk);
    addr = a; wdata = d; wr = 1'b1; cs = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0; cs = 1'b0;
    e = cyc;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    int e;
    bus_write_at(0, a, d, e);
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1; cs = 1'b1;
    #1;
    d = rdata;
    rd = 1'b0; cs = 1'b0;
  endtask

  task automatic read_digest(output logic [255:0] dg);
    logic [31:0] w;
    for (int i = 0; i < 8; i++) begin
      bus_read(5'(24 + i), w);
      dg[32*i +: 32] = w;
    end
  endtask

  task automatic start_hash(input logic [31:0] ctrl, input string tag, input logic [255:0] dg,
                            input logic valid, output int e);
    sb.push_back('{tag, dg, valid});
    bus_write_at(0, 5'd0, ctrl, e);
  endtask

  task automatic wait_result(input int e);
    logic [31:0]  st;
    logic [255:0] dg;
    exp_t         x;
    int           lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      bus_read(5'd0, st);
      if (i == 0) chk("busy_during_hash", st[0], 1'b1);
      if (st[1]) begin
        lat = cyc - e;
        break;
      end
    end
    chk("done_latency", lat, 66);
    chk("busy_after_done", st[0], 1'b0);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
    end else begin
      x = sb.pop_front();
      read_digest(dg);
      chk({x.tag, "_digest"}, dg, x.digest);
      chk({x.tag, "_valid"}, st[2], x.valid);
    end
  endtask

  initial begin
    logic [31:0]  r;
    logic [255:0] dg;
    int           e, e2, e3;

    n_rst = 1'b0; wr = 1'b0; rd = 1'b0; cs = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;

    // reset state
    bus_read(5'd0, r);  chk("reset_status", r, 0);
    bus_read(5'd1, r);  chk("reset_len", r, 0);
    bus_read(5'd16, r); chk("reset_target", r, 0);
    read_digest(dg);    chk("reset_digest", dg, 0);

    // empty message
    start_hash(32'h2, "empty", DIG_EMPTY, 1'b0, e);
    wait_result(e);

    // "a"
    bus_write(5'd15, 32'h61000000);
    bus_write(5'd1, 32'd8);
    start_hash(32'h2, "a", DIG_A, 1'b0, e);
    wait_result(e);

    // length saturation, ignored address 2, idle read strobe
    bus_write(5'd1, 32'h1ff);
    bus_read(5'd1, r); chk("len_saturate", r, 416);
    bus_write(5'd2, 32'hdeadbeef);
    bus_read(5'd2, r); chk("addr2_zero", r, 0);
    addr = 5'd1; cs = 1'b1; rd = 1'b0; #1;
    chk("read_strobe_low", rdata, 0);
    cs = 1'b0;

    // "abc" against an all-ones target, committed in the same write as start
    bus_write(5'd15, 32'h61626300);
    bus_write(5'd1, 32'd24);
    bus_read(5'd15, r); chk("msg_readback", r, 32'h61626300);
    for (int i = 16; i < 24; i++) bus_write(5'(i), 32'hffffffff);
    start_hash(32'h3, "abc_under_ones", DIG_ABC, 1'b1, e);
    wait_result(e);

    // tighter target committed separately
    bus_write(5'd23, 32'h0fffffff);
    bus_write(5'd0, 32'h1);
    for (int i = 16; i < 24; i++) begin
      bus_read(5'(i), r);
      chk($sformatf("target_rd_%0d", i), r, (i == 23) ? 32'h0fffffff : 32'hffffffff);
    end
    start_hash(32'h2, "abc_over_target", DIG_ABC, 1'b0, e);
    wait_result(e);

    // writes and a second start while busy leave the running hash alone
    bus_write(5'd15, 32'h61000000);
    bus_write(5'd1, 32'd8);
    start_hash(32'h2, "a_overlap", DIG_A, 1'b0, e);
    bus_write_at(e + 10, 5'd0, 32'h2, e2);
    chk("second_start_edge", e2, e + 10);
    bus_write_at(e + 20, 5'd15, 32'h61626300, e3);
    bus_write(5'd1, 32'd24);
    wait_result(e);

    // the staged rewrite is picked up by the next start
    start_hash(32'h2, "abc_after_overlap", DIG_ABC, 1'b0, e);
    wait_result(e);

    // reset in the middle of a hash
    bus_write_at(0, 5'd0, 32'h2, e);
    @(negedge clk);
    while (cyc < e + 29) @(negedge clk);
    n_rst = 1'b0;
    @(posedge clk);
    #1 n_rst = 1'b1;
    bus_read(5'd0, r);  chk("abort_status", r, 0);
    read_digest(dg);    chk("abort_digest", dg, 0);
    bus_read(5'd1, r);  chk("abort_len", r, 0);
    bus_read(5'd23, r); chk("abort_target", r, 0);
    repeat (40) @(posedge clk);
    #1;
    bus_read(5'd0, r);  chk("abort_stays_idle", r, 0);

    start_hash(32'h2, "empty_after_reset", DIG_EMPTY, 1'b0, e);
    wait_result(e);

    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/top_level_miner.md
TOP_LEVEL_MINER -- requirements
Module: top_level_miner

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 n_rst  in  1  reset; synchronous, active-low.
REQ-004 slaveAddr  in  5  word address of the register map.
REQ-005 slaveWriteData  in  32  write data.
REQ-006 slaveWrite  in  1  write strobe; acts only when slaveChipSelect=1.
REQ-007 slaveRead  in  1  read strobe; acts only when slaveChipSelect=1.
REQ-008 slaveChipSelect  in  1  slave select.
REQ-009 slaveReadData  out  32  read data; combinational, zero wait states; 0 when not (slaveRead & slaveChipSelect).

Function
REQ-010 Write map: 0 = control; 1 = message length L in bits (bits[8:0], values >416 saturate to 416); 3..15 = message buffer, addr 15 = bits[415:384] (first message bytes), addr 3 = bits[31:0]; 16..23 = staged target, addr 23 = target[255:224], addr 16 = target[31:0]; addrs 2 and 24..31 are ignored on write.
REQ-011 Control write: bit0=1 copies staged target to committed target; bit1=1 starts a hash. Both bits set in one write: commit first, then start, so the hash compares against the new target.
REQ-012 Read map: 0 = {29'b0, validBTC, done, busy}; 1 = L; 3..15 = message buffer; 16..23 = committed target; 24..31 = digest, addr 31 = digest[255:224]; addr 2 = 0.
REQ-013 Start snapshots message buffer and L. Block = top L bits of buffer, then bit 1, zeros, then 64-bit big-endian L (standard single-block SHA-256 padding).
REQ-014 FSM states: IDLE, ROUND, FINAL, COMPARE, DONE. Start in IDLE or DONE enters ROUND with a,b,..,h = SHA-256 IV, busy=1, done=0.
REQ-015 ROUND: one SHA-256 round per cycle for 64 cycles, with a 16-word rolling message schedule. FINAL: digest = IV + working vars, word-wise mod 2^32. COMPARE: validBTC = (digest < committed target), unsigned 256-bit, strict; then DONE.
REQ-016 Latency: if the start write is sampled at edge E, digest is valid and done=1, busy=0 from edge E+66.
REQ-017 A start received while busy is ignored. Message, length and target writes during busy update the staged registers only and do not affect the running hash. A target commit during busy applies to the next compare.
REQ-018 done and validBTC hold until the next start. A new start clears done and validBTC.

Reset
REQ-019 When n_rst=0 at a clock edge:
- FSM returns to IDLE.
- Message buffer, L, staged and committed target, and digest clear to 0.
- busy, done and validBTC go to 0.
REQ-020 A reset during hashing aborts the hash. The first start after reset behaves normally.

Structure
REQ-021 Shared package miner_pkg SHALL hold:
- the 64 K round constants;
- the 8 IV words;
- the register-address localparams;
- the FSM state enum.
REQ-022 The round logic, schedule and digest add SHALL be in one sub-module sha256_core (start, block[511:0] in; busy, done, digest[255:0] out). The top holds the register file, padding, compare and bus logic.

Verification
REQ-023 Reset, L=0, start -> at E+66, digest = e3b0c442...7852b855, done=1.
REQ-024 addr15=0x61000000, L=8, start -> digest ca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb.
REQ-025 Target all-F committed, addr15=0x61626300, L=24, start -> digest ba7816bf...f20015ad, validBTC=1.
REQ-026 Target 0x0FFF...F committed via addrs 23..16 then control 0x1, same "abc" hash -> validBTC=0; reads of 16..23 return the target.
REQ-027 Start, second start at E+10, message rewritten at E+20 -> first hash result unchanged at E+66.
REQ-028 n_rst=0 at E+30 -> status=0 and digest=0; a new start then completes correctly.
